// File: rtl/multi_source_recovery_manager_if.sv
// Request/broadcast bundle between the flush sources, the pipeline and the recovery manager.
// The master side raises requests and consumes the recovery broadcast; the manager is the slave.
interface multi_source_recovery_manager_if #(
  parameter int NUM_SRC        = 2,
  parameter int AL_INDEX_WIDTH = 6,
  parameter int PC_WIDTH       = 32,
  parameter int HIST_WIDTH     = 10,
  parameter int NUM_BUSY       = 2,
  parameter int CNT_WIDTH      = 16
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]                req_valid;
  logic [2*NUM_SRC-1:0]              req_type;
  logic [PC_WIDTH*NUM_SRC-1:0]       req_pc;
  logic [AL_INDEX_WIDTH*NUM_SRC-1:0] req_op_ptr;
  logic [AL_INDEX_WIDTH*NUM_SRC-1:0] req_flush_tail;
  logic [HIST_WIDTH*NUM_SRC-1:0]     req_hist;
  logic [AL_INDEX_WIDTH-1:0]         al_head_ptr;
  logic [PC_WIDTH-1:0]               csr_target_pc;
  logic [NUM_BUSY-1:0]               busy;

  logic [1:0]                        phase;
  logic                              to_recovery_phase;
  logic                              to_commit_phase;
  logic                              flush_upper;
  logic                              csr_trigger;
  logic [PC_WIDTH-1:0]               recovered_pc;
  logic [HIST_WIDTH-1:0]             recovered_hist;
  logic [AL_INDEX_WIDTH-1:0]         flush_head_ptr;
  logic [AL_INDEX_WIDTH-1:0]         flush_tail_ptr;
  logic [SRC_W-1:0]                  recovery_src;
  logic                              unable_to_start;
  logic [CNT_WIDTH-1:0]              cnt_type0;
  logic [CNT_WIDTH-1:0]              cnt_type1;
  logic [CNT_WIDTH-1:0]              cnt_type2;
  logic [CNT_WIDTH-1:0]              cnt_type3;
  logic [CNT_WIDTH-1:0]              cnt_dropped;

  modport master (
    output req_valid, req_type, req_pc, req_op_ptr, req_flush_tail, req_hist,
           al_head_ptr, csr_target_pc, busy,
    input  phase, to_recovery_phase, to_commit_phase, flush_upper, csr_trigger,
           recovered_pc, recovered_hist, flush_head_ptr, flush_tail_ptr, recovery_src,
           unable_to_start, cnt_type0, cnt_type1, cnt_type2, cnt_type3, cnt_dropped
  );

  modport slave (
    input  req_valid, req_type, req_pc, req_op_ptr, req_flush_tail, req_hist,
           al_head_ptr, csr_target_pc, busy,
    output phase, to_recovery_phase, to_commit_phase, flush_upper, csr_trigger,
           recovered_pc, recovered_hist, flush_head_ptr, flush_tail_ptr, recovery_src,
           unable_to_start, cnt_type0, cnt_type1, cnt_type2, cnt_type3, cnt_dropped
  );
endinterface

// File: rtl/multi_source_recovery_manager.sv
// Oldest-first arbitration of pipeline flush requests, phased recovery sequencing with busy drain,
// and saturating per-refetch-type event counters. A small checker module carries the assertions.
module multi_source_recovery_manager_chk #(
  parameter int RECOVER_PHASES = 2
) (
  input logic       clk,
  input logic       rst,
  input logic       toCommitPhase,
  input logic       accept,
  input logic [1:0] phase
);
  // Accepting and returning to commit are mutually exclusive; the middle phase needs >2 phases.
  assert property (@(posedge clk) disable iff (rst) !(toCommitPhase && accept));
  assert property (@(posedge clk) disable iff (rst) !((RECOVER_PHASES == 2) && (phase == 2'd2)));
endmodule

module multi_source_recovery_manager #(
  parameter int NUM_SRC        = 2,
  parameter int AL_INDEX_WIDTH = 6,
  parameter int PC_WIDTH       = 32,
  parameter int HIST_WIDTH     = 10,
  parameter int NUM_BUSY       = 2,
  parameter int RECOVER_PHASES = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int INSN_BYTES     = 4
) (
  input logic clk,
  input logic rst,
  multi_source_recovery_manager_if.slave bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int K_W   = (RECOVER_PHASES > 2) ? $clog2(RECOVER_PHASES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(RECOVER_PHASES - 2);

  typedef enum logic [1:0] {
    COMMIT      = 2'd0,
    RECOVER_0   = 2'd1,
    RECOVER_MID = 2'd2,
    DRAIN       = 2'd3
  } phase_e;

  function automatic logic [CNT_WIDTH-1:0] satAdd(input logic [CNT_WIDTH-1:0] a,
                                                  input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    satAdd = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  phase_e                    curState_r, nextState_s;
  logic [K_W-1:0]            k_r, nextK_s;
  logic [1:0]                latchedType_r;
  logic [PC_WIDTH-1:0]       latchedPc_r;
  logic [HIST_WIDTH-1:0]     latchedHist_r;
  logic [AL_INDEX_WIDTH-1:0] flushHead_r, flushTail_r;
  logic [SRC_W-1:0]          latchedSrc_r;
  logic [CNT_WIDTH-1:0]      cntType_r [4];
  logic [CNT_WIDTH-1:0]      cntDropped_r;

  logic                      winFound_s, take_s, accept_s, unable_s, toRecovery_s, toCommit_s;
  logic [SRC_W-1:0]          winIdx_s;
  logic [AL_INDEX_WIDTH-1:0] winAge_s, age_s, winPtr_s, winTail_s, winHead_s;
  logic [1:0]                winType_s;
  logic [PC_WIDTH-1:0]       winPc_s, recPc_s;
  logic [HIST_WIDTH-1:0]     winHist_s;
  logic [CNT_WIDTH-1:0]      validCnt_s, dropInc_s;

  // Oldest-op arbitration: strict less-than keeps the lowest index on equal ages.
  always_comb begin
    winFound_s = 1'b0;
    winIdx_s   = '0;
    winAge_s   = '0;
    winType_s  = 2'd0;
    winPc_s    = '0;
    winPtr_s   = '0;
    winTail_s  = '0;
    winHist_s  = '0;
    validCnt_s = '0;
    age_s      = '0;
    take_s     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      age_s      = bus.req_op_ptr[i*AL_INDEX_WIDTH +: AL_INDEX_WIDTH] - bus.al_head_ptr;
      take_s     = bus.req_valid[i] && (!winFound_s || (age_s < winAge_s));
      validCnt_s = bus.req_valid[i] ? validCnt_s + CNT_WIDTH'(1) : validCnt_s;
      winIdx_s   = take_s ? SRC_W'(i) : winIdx_s;
      winAge_s   = take_s ? age_s : winAge_s;
      winType_s  = take_s ? bus.req_type[i*2 +: 2] : winType_s;
      winPc_s    = take_s ? bus.req_pc[i*PC_WIDTH +: PC_WIDTH] : winPc_s;
      winPtr_s   = take_s ? bus.req_op_ptr[i*AL_INDEX_WIDTH +: AL_INDEX_WIDTH] : winPtr_s;
      winTail_s  = take_s ? bus.req_flush_tail[i*AL_INDEX_WIDTH +: AL_INDEX_WIDTH] : winTail_s;
      winHist_s  = take_s ? bus.req_hist[i*HIST_WIDTH +: HIST_WIDTH] : winHist_s;
      winFound_s = winFound_s || take_s;
    end
    unable_s  = (curState_r != COMMIT) || (|bus.busy);
    accept_s  = winFound_s && !unable_s;
    dropInc_s = validCnt_s - (accept_s ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}});
    // Next-PC and branch-target refetches keep the faulting op itself, so flushing starts after it.
    winHead_s = ((winType_s == 2'd1) || (winType_s == 2'd2)) ?
                winPtr_s + AL_INDEX_WIDTH'(1) : winPtr_s;
  end

  // Phase sequencing: RECOVER_0, optional middle sub-phases, then drain until busy clears.
  always_comb begin
    nextState_s = curState_r;
    nextK_s     = k_r;
    case (curState_r)
      COMMIT: begin
        nextState_s = accept_s ? RECOVER_0 : COMMIT;
      end
      RECOVER_0: begin
        if (RECOVER_PHASES > 2) begin
          nextState_s = RECOVER_MID;
          nextK_s     = K_W'(1);
        end else begin
          nextState_s = DRAIN;
          nextK_s     = '0;
        end
      end
      RECOVER_MID: begin
        if (k_r >= K_LAST) begin
          nextState_s = DRAIN;
          nextK_s     = '0;
        end else begin
          nextState_s = RECOVER_MID;
          nextK_s     = k_r + K_W'(1);
        end
      end
      DRAIN: begin
        nextState_s = (|bus.busy) ? DRAIN : COMMIT;
      end
      default: begin
        nextState_s = COMMIT;
        nextK_s     = '0;
      end
    endcase
  end

  // State register plus recovery context captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState_r    <= COMMIT;
      k_r           <= '0;
      latchedType_r <= 2'd0;
      latchedPc_r   <= '0;
      latchedHist_r <= '0;
      flushHead_r   <= '0;
      flushTail_r   <= '0;
      latchedSrc_r  <= '0;
    end else begin
      curState_r <= nextState_s;
      k_r        <= nextK_s;
      if (accept_s) begin
        latchedType_r <= winType_s;
        latchedPc_r   <= winPc_s;
        latchedHist_r <= winHist_s;
        flushHead_r   <= winHead_s;
        flushTail_r   <= winTail_s;
        latchedSrc_r  <= winIdx_s;
      end
    end
  end

  // Saturating event counters: one per refetch type, plus dropped requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cntType_r[i] <= '0;
      end
      cntDropped_r <= '0;
    end else begin
      cntDropped_r <= satAdd(cntDropped_r, dropInc_s);
      if (curState_r == RECOVER_0) begin
        cntType_r[latchedType_r] <= satAdd(cntType_r[latchedType_r], CNT_WIDTH'(1));
      end
    end
  end

  // Recovered PC is only meaningful in RECOVER_0; the CSR target is taken live that cycle.
  always_comb begin
    toRecovery_s = (curState_r == RECOVER_0);
    toCommit_s   = (curState_r == DRAIN) && !(|bus.busy);
    case (latchedType_r)
      2'd1:    recPc_s = latchedPc_r + PC_WIDTH'(INSN_BYTES);
      2'd3:    recPc_s = bus.csr_target_pc;
      default: recPc_s = latchedPc_r;
    endcase
    if (!toRecovery_s) begin
      recPc_s = '0;
    end else begin
      recPc_s = recPc_s;
    end
  end

  assign bus.phase             = curState_r;
  assign bus.to_recovery_phase = toRecovery_s;
  assign bus.to_commit_phase   = toCommit_s;
  assign bus.flush_upper       = toRecovery_s;
  assign bus.csr_trigger       = toRecovery_s && (latchedType_r == 2'd3);
  assign bus.recovered_pc      = recPc_s;
  assign bus.recovered_hist    = latchedHist_r;
  assign bus.flush_head_ptr    = flushHead_r;
  assign bus.flush_tail_ptr    = flushTail_r;
  assign bus.recovery_src      = latchedSrc_r;
  assign bus.unable_to_start   = unable_s;
  assign bus.cnt_type0         = cntType_r[0];
  assign bus.cnt_type1         = cntType_r[1];
  assign bus.cnt_type2         = cntType_r[2];
  assign bus.cnt_type3         = cntType_r[3];
  assign bus.cnt_dropped       = cntDropped_r;

  multi_source_recovery_manager_chk #(.RECOVER_PHASES(RECOVER_PHASES)) u_chk (
    .clk           (clk),
    .rst           (rst),
    .toCommitPhase (toCommit_s),
    .accept        (accept_s),
    .phase         (curState_r)
  );
endmodule
